fetch_control: RTL and testbench

- Program-counter and fetch sequencer for the 9-bit-ISA core.
- Drives current_pc into the instruction memory, which returns the 9-bit instruction combinationally in the same cycle.
- Takes start, halt, stall and branch-redirect inputs from the decode/execute stage and runs an IDLE/RUN/HALTED state machine.
- Reports done to the testbench/top level and keeps a retired-instruction counter for performance checks.

---
 rtl/fetch_control.sv | 97 +++++++++
 tb/tb_fetch_control.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_control.sv
// Program-counter and fetch sequencer: IDLE/RUN/HALTED control with start,
// halt, stall and branch redirect, plus a saturating retired-instruction count.
module fetch_control #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [ADDR_BITS-1:0] branch_target,
  output logic [PC_WIDTH-1:0]  current_pc,
  output logic                 running,
  output logic                 done,
  output logic [31:0]          instr_count,
  output logic                 pc_wrapped
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [ADDR_BITS-1:0] START_PC = ADDR_BITS'(START_ADDR);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [31:0]          count_q, count_d;
  logic                 wrap_q, wrap_d;
  logic [31:0]          count_inc;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case/if tree can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_RUN;
      S_RUN:            if (halt)  state_d = S_HALTED;
      default:                     state_d = S_IDLE;
    endcase
  end

  // The count sticks at all-ones rather than wrapping.
  assign count_inc = (&count_q) ? count_q : count_q + 32'd1;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    if (state_q != S_RUN) begin
      if (start) begin
        pc_d    = START_PC;
        count_d = '0;
        wrap_d  = 1'b0;
      end
    end else if (halt) begin
      count_d = count_inc;
    end else if (!stall) begin
      count_d = count_inc;
      if (branch_taken) begin
        pc_d = branch_target;
      end else begin
        pc_d = pc_q + ADDR_BITS'(1);
        if (&pc_q) wrap_d = 1'b1;
      end
    end
  end

  always_comb begin
    running     = (state_q == S_RUN);
    done        = (state_q == S_HALTED);
    current_pc  = PC_WIDTH'(pc_q);
    instr_count = count_q;
    pc_wrapped  = wrap_q;
  end

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_fetch_control;

  localparam int PCW   = 32;
  localparam int AW    = 12;
  localparam int START = 0;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, halt, stall, branch_taken;
  logic [AW-1:0] branch_target;
  logic [PCW-1:0] current_pc;
  logic          running, done, pc_wrapped;
  logic [31:0]   instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_control #(
    .PC_WIDTH  (PCW),
    .ADDR_BITS (AW),
    .START_ADDR(START)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .halt         (halt),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .current_pc   (current_pc),
    .running      (running),
    .done         (done),
    .instr_count  (instr_count),
    .pc_wrapped   (pc_wrapped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time,
               actual, expected);
    end
  endtask

  // Behavioural model: plain flags and integer arithmetic.
  bit     m_running, m_done, m_wrap;
  int     m_pc;
  longint m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_running = 0; m_done = 0; m_wrap = 0; m_pc = 0; m_cnt = 0;
    end else if (!m_running) begin
      if (start) begin
        m_running = 1; m_done = 0; m_pc = START; m_cnt = 0; m_wrap = 0;
      end
    end else if (halt) begin
      m_running = 0; m_done = 1;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end else if (!stall) begin
      if (branch_taken) m_pc = int'(branch_target);
      else begin
        if (m_pc == DEPTH - 1) m_wrap = 1;
        m_pc = (m_pc + 1) % DEPTH;
      end
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
  end

  always @(negedge clk) begin
    check("pc",          current_pc,  64'(m_pc));
    check("running",     running,     64'(m_running));
    check("done",        done,        64'(m_done));
    check("instr_count", instr_count, 64'(m_cnt));
    check("pc_wrapped",  pc_wrapped,  64'(m_wrap));
  end

  task automatic step(input logic st, input logic h, input logic s,
                      input logic b, input logic [AW-1:0] tgt);
    start = st; halt = h; stall = s; branch_taken = b; branch_target = tgt;
    @(posedge clk);
    #1;
    start = 0; halt = 0; stall = 0; branch_taken = 0; branch_target = '0;
  endtask

  initial begin
    reset = 1; start = 0; halt = 0; stall = 0; branch_taken = 0;
    branch_target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc",      current_pc,  0);
    check("rst_running", running,     0);
    check("rst_done",    done,        0);
    check("rst_count",   instr_count, 0);
    check("rst_wrap",    pc_wrapped,  0);
    reset = 0;

    // Start, then free-run five cycles.
    step(1, 0, 0, 0, '0);
    check("start_pc",      current_pc, 0);
    check("start_running", running,    1);
    repeat (5) step(0, 0, 0, 0, '0);
    check("run5_pc",    current_pc,  5);
    check("run5_count", instr_count, 5);

    // Stall at pc 7 with branch_taken presented during the stall.
    repeat (2) step(0, 0, 0, 0, '0);
    check("pre_stall_pc", current_pc, 7);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 12'h020);
      check("stall_pc",    current_pc,  7);
      check("stall_count", instr_count, 7);
    end
    step(0, 0, 0, 1, 12'h020);
    check("branch_pc",    current_pc,  32'h20);
    check("branch_count", instr_count, 8);

    // Halt together with a branch at pc 3, then restart.
    step(0, 0, 0, 1, 12'h003);
    step(0, 1, 0, 1, 12'h055);
    check("halt_pc",      current_pc,  3);
    check("halt_done",    done,        1);
    check("halt_running", running,     0);
    check("halt_count",   instr_count, 10);
    step(0, 0, 0, 0, '0);
    check("halted_hold_pc", current_pc, 3);
    step(1, 0, 0, 0, '0);
    check("restart_pc",    current_pc,  START);
    check("restart_count", instr_count, 0);
    check("restart_done",  done,        0);

    // Wrap from the top of instruction memory.
    step(0, 0, 0, 1, 12'hFFE);
    check("ffe_pc", current_pc, 32'hFFE);
    step(0, 0, 0, 0, '0);
    check("fff_pc",   current_pc, 32'hFFF);
    check("fff_wrap", pc_wrapped, 0);
    step(0, 0, 0, 0, '0);
    check("wrap0_pc",   current_pc, 0);
    check("wrap0_wrap", pc_wrapped, 1);
    step(0, 0, 0, 0, '0);
    check("wrap1_pc",    current_pc,  1);
    check("wrap1_wrap",  pc_wrapped,  1);
    check("wrap1_upper", current_pc[PCW-1:AW], 0);
    check("wrap1_count", instr_count, 4);

    // Start during RUN is ignored.
    step(0, 0, 0, 1, 12'h009);
    step(1, 0, 0, 0, '0);
    check("ign_start_pc",    current_pc,  32'hA);
    check("ign_start_count", instr_count, 6);
    check("ign_start_wrap",  pc_wrapped,  1);

    // Asynchronous reset mid-cycle.
    step(0, 0, 0, 1, 12'h045);
    check("pre_rst_pc", current_pc, 32'h45);
    #2 reset = 1;
    #1;
    check("arst_pc",      current_pc,  0);
    check("arst_running", running,     0);
    check("arst_done",    done,        0);
    check("arst_count",   instr_count, 0);
    check("arst_wrap",    pc_wrapped,  0);
    @(posedge clk);
    #1 reset = 0;
    repeat (2) begin
      step(0, 0, 0, 0, '0);
      check("post_rst_pc",      current_pc, 0);
      check("post_rst_running", running,    0);
    end

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom_range(0, 9) < 3);
      halt          = ($urandom_range(0, 99) < 4);
      stall         = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 15);
      branch_target = ($urandom_range(0, 3) == 0) ?
                      AW'($urandom_range(DEPTH - 6, DEPTH - 1)) :
                      AW'($urandom_range(0, DEPTH - 1));
      reset         = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    reset = 0; start = 0; halt = 0; stall = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
